// File: rtl/spr_pkg.sv
// rtl/spr_pkg.sv - field codes, default widths and the per-sprite attribute record
package spr_pkg;
  localparam int CORDW = 16;
  localparam int NSPR  = 4;
  localparam int VELW  = 8;

  localparam logic [1:0] FLD_X    = 2'd0;
  localparam logic [1:0] FLD_Y    = 2'd1;
  localparam logic [1:0] FLD_CTRL = 2'd2;
  localparam logic [1:0] FLD_VEL  = 2'd3;

  typedef struct packed {
    logic [VELW-1:0] vy;
    logic [VELW-1:0] vx;
  } spr_vel_t;

  typedef struct packed {
    logic [CORDW-1:0] x;
    logic [CORDW-1:0] y;
    logic             en;
    spr_vel_t         vel;
  } spr_attr_t;

  function automatic logic [CORDW-1:0] sext_vel(input logic [VELW-1:0] v);
    return {{(CORDW-VELW){v[VELW-1]}}, v};
  endfunction
endpackage

// File: rtl/sprite_attr_entry.sv
// rtl/sprite_attr_entry.sv - one sprite's shadow/active registers; SPR_AUTO_MOVE_EN adds velocity motion
module sprite_attr_entry
  import spr_pkg::*;
(
  input  logic             clk_25MHz,
  input  logic             btn_rst_n,
  input  logic             frame,
  input  logic             commit,
  input  logic             wr_en,
  input  logic [1:0]       wr_field,
  input  logic [CORDW-1:0] wr_data,
  output logic [CORDW-1:0] spr_x,
  output logic [CORDW-1:0] spr_y,
  output logic             spr_en
);
`ifdef SPR_AUTO_MOVE_EN
  localparam bit AUTO_MOVE = 1'b1;
`else
  localparam bit AUTO_MOVE = 1'b0;
`endif

  spr_attr_t shd;
  spr_attr_t act;

  // Commit reads the pre-write shadow, so a same-cycle write waits for the next commit.
  always_ff @(posedge clk_25MHz or negedge btn_rst_n) begin
    if (!btn_rst_n) begin
      shd <= '0;
      act <= '0;
    end else begin
      if (wr_en) begin
        case (wr_field)
          FLD_X:    shd.x  <= wr_data;
          FLD_Y:    shd.y  <= wr_data;
          FLD_CTRL: shd.en <= wr_data[0];
          default:  if (AUTO_MOVE) shd.vel <= wr_data[2*VELW-1:0];
        endcase
      end
      if (commit) begin
        act <= shd;
      end else if (AUTO_MOVE && frame && act.en) begin
        act.x <= act.x + sext_vel(act.vel.vx);
        act.y <= act.y + sext_vel(act.vel.vy);
      end
    end
  end

  assign spr_x  = act.x;
  assign spr_y  = act.y;
  assign spr_en = act.en;
endmodule

// File: rtl/sprite_attr_table.sv
// rtl/sprite_attr_table.sv - frame-synchronised sprite attribute table; SPR_AUTO_MOVE_EN enables motion
module sprite_attr_table #(
  parameter int NSPR  = spr_pkg::NSPR,
  parameter int CORDW = spr_pkg::CORDW,
  parameter int IDXW  = (NSPR > 1) ? $clog2(NSPR) : 1
) (
  input  logic              clk_25MHz,
  input  logic              btn_rst_n,
  input  logic              frame,
  input  logic              wr_en,
  input  logic [IDXW-1:0]   wr_idx,
  input  logic [1:0]        wr_field,
  input  logic [CORDW-1:0]  wr_data,
  input  logic              commit_req,
  output logic              commit_pending,
  output logic [NSPR*CORDW-1:0] spr_x,
  output logic [NSPR*CORDW-1:0] spr_y,
  output logic [NSPR-1:0]   spr_en,
  output logic [15:0]       frame_cnt
);
  import spr_pkg::*;

  typedef enum logic {IDLE, ARMED} state_t;
  state_t state;
  logic   do_commit;

  assign do_commit = frame && (state == ARMED);

  // A request arriving with frame while idle arms for the following frame.
  always_ff @(posedge clk_25MHz or negedge btn_rst_n) begin
    if (!btn_rst_n) begin
      state          <= IDLE;
      commit_pending <= 1'b0;
      frame_cnt      <= '0;
    end else begin
      if (frame) frame_cnt <= frame_cnt + 16'd1;
      case (state)
        IDLE: if (commit_req) begin
          state          <= ARMED;
          commit_pending <= 1'b1;
        end
        ARMED: if (frame) begin
          state          <= IDLE;
          commit_pending <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NSPR; i++) begin : g_spr
    logic hit;
    assign hit = wr_en && (wr_idx == IDXW'(i));

    sprite_attr_entry u_entry (
      .clk_25MHz (clk_25MHz),
      .btn_rst_n (btn_rst_n),
      .frame     (frame),
      .commit    (do_commit),
      .wr_en     (hit),
      .wr_field  (wr_field),
      .wr_data   (wr_data),
      .spr_x     (spr_x[i*CORDW +: CORDW]),
      .spr_y     (spr_y[i*CORDW +: CORDW]),
      .spr_en    (spr_en[i])
    );
  end
endmodule

// File: tb/tb_sprite_attr_table.sv
// tb/tb_sprite_attr_table.sv - randomized self-checking bench against a behavioural table model
module tb_sprite_attr_table;
  localparam int NSPR  = 4;
  localparam int CORDW = 16;
  localparam int IDXW  = 3;
`ifdef SPR_AUTO_MOVE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk_25MHz = 1'b0;
  logic btn_rst_n = 1'b0;
  logic frame = 1'b0, wr_en = 1'b0, commit_req = 1'b0;
  logic [IDXW-1:0] wr_idx = '0;
  logic [1:0] wr_field = '0;
  logic [CORDW-1:0] wr_data = '0;
  logic commit_pending;
  logic [NSPR*CORDW-1:0] spr_x, spr_y;
  logic [NSPR-1:0] spr_en;
  logic [15:0] frame_cnt;

  int errors = 0;
  int checks = 0;

  logic [15:0] m_sx[NSPR], m_sy[NSPR], m_sv[NSPR];
  logic [15:0] m_ax[NSPR], m_ay[NSPR], m_av[NSPR];
  bit m_sen[NSPR], m_aen[NSPR];
  bit m_armed;
  int m_fcnt;

  sprite_attr_table #(.NSPR(NSPR), .CORDW(CORDW), .IDXW(IDXW)) dut (
    .clk_25MHz(clk_25MHz), .btn_rst_n(btn_rst_n), .frame(frame), .wr_en(wr_en),
    .wr_idx(wr_idx), .wr_field(wr_field), .wr_data(wr_data), .commit_req(commit_req),
    .commit_pending(commit_pending), .spr_x(spr_x), .spr_y(spr_y), .spr_en(spr_en),
    .frame_cnt(frame_cnt)
  );

  always #5 clk_25MHz = ~clk_25MHz;

  function automatic logic [15:0] vel_delta(input logic [7:0] b);
    int v;
    v = int'(b);
    if (v >= 128) v -= 256;
    return 16'(v);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NSPR; i++) begin
      m_sx[i] = 0; m_sy[i] = 0; m_sv[i] = 0; m_sen[i] = 0;
      m_ax[i] = 0; m_ay[i] = 0; m_av[i] = 0; m_aen[i] = 0;
    end
    m_armed = 0;
    m_fcnt = 0;
  endtask

  task automatic model_edge(input bit f, input bit we, input int idx, input int fld,
                            input logic [15:0] d, input bit cr);
    bit commit;
    commit = f && m_armed;
    for (int i = 0; i < NSPR; i++) begin
      if (commit) begin
        m_ax[i] = m_sx[i]; m_ay[i] = m_sy[i]; m_aen[i] = m_sen[i]; m_av[i] = m_sv[i];
      end else if (f && AUTO && m_aen[i]) begin
        m_ax[i] = m_ax[i] + vel_delta(m_av[i][7:0]);
        m_ay[i] = m_ay[i] + vel_delta(m_av[i][15:8]);
      end
    end
    if (we && idx < NSPR) begin
      case (fld)
        0: m_sx[idx] = d;
        1: m_sy[idx] = d;
        2: m_sen[idx] = d[0];
        default: if (AUTO) m_sv[idx] = d;
      endcase
    end
    if (f) m_fcnt = (m_fcnt + 1) % 65536;
    if (commit) m_armed = 0;
    else if (cr) m_armed = 1;
  endtask

  function automatic logic [NSPR*CORDW-1:0] exp_x();
    logic [NSPR*CORDW-1:0] v;
    for (int i = 0; i < NSPR; i++) v[i*CORDW +: CORDW] = m_ax[i];
    return v;
  endfunction

  function automatic logic [NSPR*CORDW-1:0] exp_y();
    logic [NSPR*CORDW-1:0] v;
    for (int i = 0; i < NSPR; i++) v[i*CORDW +: CORDW] = m_ay[i];
    return v;
  endfunction

  function automatic logic [NSPR-1:0] exp_en();
    logic [NSPR-1:0] v;
    for (int i = 0; i < NSPR; i++) v[i] = m_aen[i];
    return v;
  endfunction

  task automatic step(input bit f, input bit we, input int idx, input int fld,
                      input logic [15:0] d, input bit cr);
    frame = f; wr_en = we; wr_idx = IDXW'(idx); wr_field = 2'(fld); wr_data = d; commit_req = cr;
    @(posedge clk_25MHz);
    model_edge(f, we, idx, fld, d, cr);
    #1;
    frame = 0; wr_en = 0; commit_req = 0;
  endtask

  task automatic test_reset();
    model_reset();
    btn_rst_n = 0;
    repeat (3) @(posedge clk_25MHz);
    #1 btn_rst_n = 1;
    step(0, 0, 0, 0, 0, 0);
    checks++; if (spr_x !== '0) begin errors++; $display("FAIL reset_x: got %h want 0", spr_x); end
    checks++; if (spr_y !== '0) begin errors++; $display("FAIL reset_y: got %h want 0", spr_y); end
    checks++; if (spr_en !== '0) begin errors++; $display("FAIL reset_en: got %b want 0", spr_en); end
    checks++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b want 0", commit_pending); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", frame_cnt); end
  endtask

  task automatic test_write_commit();
    step(0, 1, 1, 0, 16'd300, 0);
    step(0, 1, 1, 1, 16'd215, 0);
    step(0, 1, 1, 2, 16'd1, 0);
    step(0, 0, 0, 0, 0, 1);
    checks++; if (commit_pending !== 1'b1) begin errors++; $display("FAIL wc_pending: got %b want 1", commit_pending); end
    step(0, 0, 0, 0, 0, 0);
    checks++; if (spr_x !== '0 || spr_en !== '0) begin errors++; $display("FAIL wc_hold: x=%h en=%b want 0", spr_x, spr_en); end
    step(1, 0, 0, 0, 0, 0);
    checks++; if (spr_x[CORDW +: CORDW] !== 16'd300 || spr_y[CORDW +: CORDW] !== 16'd215 || spr_en[1] !== 1'b1)
      begin errors++; $display("FAIL wc_pub: x=%0d y=%0d en=%b want 300/215/1", spr_x[CORDW +: CORDW], spr_y[CORDW +: CORDW], spr_en[1]); end
    checks++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL wc_drop: got %b want 0", commit_pending); end
    checks++; if (spr_x !== exp_x() || spr_y !== exp_y()) begin errors++; $display("FAIL wc_model: x=%h want %h", spr_x, exp_x()); end
  endtask

  task automatic test_req_with_frame();
    step(0, 1, 2, 0, 16'hFFCE, 0);
    step(1, 0, 0, 0, 0, 1);
    checks++; if (spr_x[2*CORDW +: CORDW] !== 16'd0) begin errors++; $display("FAIL rf_hold: got %h want 0", spr_x[2*CORDW +: CORDW]); end
    checks++; if (commit_pending !== 1'b1) begin errors++; $display("FAIL rf_pending: got %b want 1", commit_pending); end
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    checks++; if (spr_x[2*CORDW +: CORDW] !== 16'hFFCE) begin errors++; $display("FAIL rf_pub: got %h want ffce", spr_x[2*CORDW +: CORDW]); end
    checks++; if (frame_cnt !== 16'(m_fcnt)) begin errors++; $display("FAIL rf_cnt: got %0d want %0d", frame_cnt, m_fcnt); end
  endtask

  task automatic test_write_with_commit_frame();
    step(0, 1, 0, 0, 16'd10, 1);
    step(1, 1, 0, 0, 16'd20, 0);
    checks++; if (spr_x[0 +: CORDW] !== 16'd10) begin errors++; $display("FAIL wf_first: got %0d want 10", spr_x[0 +: CORDW]); end
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0);
    checks++; if (spr_x[0 +: CORDW] !== 16'd20) begin errors++; $display("FAIL wf_second: got %0d want 20", spr_x[0 +: CORDW]); end
  endtask

  task automatic test_out_of_range();
    for (int k = NSPR; k < 8; k++) begin
      step(0, 1, k, 0, 16'(($urandom % 65535) + 1), 0);
      step(0, 1, k, 2, 16'd1, 0);
    end
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0);
    checks++; if (spr_x !== exp_x() || spr_en !== exp_en()) begin errors++; $display("FAIL oor: x=%h en=%b want %h %b", spr_x, spr_en, exp_x(), exp_en()); end
  endtask

  task automatic test_auto_move();
    int c0;
    logic [15:0] want;
    step(0, 1, 3, 0, 16'd2, 0);
    step(0, 1, 3, 2, 16'd1, 0);
    step(0, 1, 3, 3, 16'h00FC, 0);
    step(0, 1, 2, 0, 16'd100, 0);
    step(0, 1, 2, 2, 16'd0, 0);
    step(0, 1, 2, 3, 16'h0505, 0);
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0);
    checks++; if (spr_x[3*CORDW +: CORDW] !== 16'd2) begin errors++; $display("FAIL am_commit: got %h want 2", spr_x[3*CORDW +: CORDW]); end
    c0 = int'(frame_cnt);
    for (int n = 1; n <= 2; n++) begin
      step(1, 0, 0, 0, 0, 0);
      want = AUTO ? 16'(2 - 4 * n) : 16'd2;
      checks++; if (spr_x[3*CORDW +: CORDW] !== want) begin errors++; $display("FAIL am_move%0d: got %h want %h", n, spr_x[3*CORDW +: CORDW], want); end
      checks++; if (spr_x[2*CORDW +: CORDW] !== 16'd100) begin errors++; $display("FAIL am_still%0d: got %h want 100", n, spr_x[2*CORDW +: CORDW]); end
      checks++; if (int'(frame_cnt) !== (c0 + n) % 65536) begin errors++; $display("FAIL am_cnt%0d: got %0d want %0d", n, frame_cnt, (c0 + n) % 65536); end
    end
    checks++; if (spr_y !== exp_y()) begin errors++; $display("FAIL am_y: got %h want %h", spr_y, exp_y()); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      step(($urandom % 6) == 0, ($urandom % 3) != 0, int'($urandom % 8), int'($urandom % 4),
           16'($urandom), ($urandom % 4) == 0);
      checks++; if (spr_x !== exp_x()) begin errors++; $display("FAIL rnd_x[%0d]: got %h want %h", n, spr_x, exp_x()); end
      checks++; if (spr_y !== exp_y()) begin errors++; $display("FAIL rnd_y[%0d]: got %h want %h", n, spr_y, exp_y()); end
      checks++; if (spr_en !== exp_en()) begin errors++; $display("FAIL rnd_en[%0d]: got %b want %b", n, spr_en, exp_en()); end
      checks++; if (commit_pending !== m_armed) begin errors++; $display("FAIL rnd_pend[%0d]: got %b want %b", n, commit_pending, m_armed); end
      checks++; if (frame_cnt !== 16'(m_fcnt)) begin errors++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", n, frame_cnt, m_fcnt); end
    end
  endtask

  task automatic test_async_reset_armed();
    step(0, 1, 1, 0, 16'd77, 0);
    step(0, 1, 1, 2, 16'd1, 1);
    step(1, 0, 0, 0, 0, 1);
    #2 btn_rst_n = 0;
    #1;
    checks++; if (spr_x !== '0 || spr_en !== '0) begin errors++; $display("FAIL ar_clear: x=%h en=%b want 0", spr_x, spr_en); end
    checks++; if (commit_pending !== 1'b0 || frame_cnt !== 16'd0) begin errors++; $display("FAIL ar_state: pend=%b cnt=%0d want 0/0", commit_pending, frame_cnt); end
    @(posedge clk_25MHz);
    #1 btn_rst_n = 1;
    model_reset();
    step(1, 0, 0, 0, 0, 0);
    checks++; if (spr_x !== '0 || commit_pending !== 1'b0) begin errors++; $display("FAIL ar_lost: x=%h pend=%b want 0/0", spr_x, commit_pending); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL ar_cnt: got %0d want 1", frame_cnt); end
  endtask

  initial begin
    test_reset();
    test_write_commit();
    test_req_with_frame();
    test_write_with_commit_frame();
    test_out_of_range();
    test_auto_move();
    test_random();
    test_async_reset_armed();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sprite_attr_table.md
# sprite_attr_table

CPU-writable sprite attribute table that sits directly upstream of the VGA sprite compositor and drives each sprite instance's `sprx`/`spry` position and its enable. The CPU writes into a shadow copy. A commit request copies shadow into the active copy only on the next `frame` pulse from `vga_control`, so positions never change mid-frame and sprites do not tear. It also keeps a free-running frame counter for software pacing.

## Interface
- `NSPR`, 4: number of sprites (1–16); `IDXW = $clog2(NSPR)`, minimum 1
- `CORDW`, 16: signed coordinate width, matching the compositor
- `clk_25MHz`  in  1  pixel clock, the same clock as `vga_control` and the compositor
- `btn_rst_n`  in  1  reset, asynchronous, active-low
- `frame`  in  1  one-cycle pulse at frame start, from `vga_control`
- `wr_en`  in  1  write strobe, one word per cycle
- `wr_idx`  in  IDXW  sprite index
- `wr_field`  in  2  field select: 0 = x, 1 = y, 2 = ctrl (bit0 = enable), 3 = velocity
- `wr_data`  in  CORDW  write data
- `commit_req`  in  1  one-cycle request to publish the shadow copy
- `commit_pending`  out  1  a commit is armed and waiting for `frame`
- `spr_x`  out  NSPR*CORDW  active x positions; sprite i is at `[i*CORDW +: CORDW]`
- `spr_y`  out  NSPR*CORDW  active y positions, same packing
- `spr_en`  out  NSPR  active enables
- `frame_cnt`  out  16  count of `frame` pulses since reset

## Operation
- **Reset:** all shadow and active fields, `spr_x`, `spr_y`, `spr_en`, `commit_pending` and `frame_cnt` go to 0.
- **Writes:**
  - When `wr_en` is high, `wr_data` goes into the shadow field addressed by (`wr_idx`, `wr_field`).
  - The ctrl field uses only `wr_data[0]`.
  - Writes with `wr_idx >= NSPR` are ignored.
  - Writes never touch the active copy.
- **Commit state machine** (2 states):
  - IDLE → ARMED on `commit_req`; `commit_pending` is high while ARMED.
  - In ARMED, `commit_req` is a no-op (there is no queueing).
  - ARMED → IDLE on `frame`: every active field is loaded from shadow, and `commit_pending` drops in the same edge.
- **Simultaneous events:**
  - A `commit_req` in the same cycle as `frame` while IDLE arms the commit; it is applied at the *next* frame.
  - A `wr_en` in the same cycle as a committing `frame` updates shadow only. The committed value is the pre-write shadow; the write is published by a later commit.
- **Frame counter:** `frame_cnt` increments on every `frame` pulse and wraps from 0xFFFF to 0.
- **Arithmetic:** two's complement at CORDW bits with no clamping. Off-screen values are legal; the compositor clips them.

## Timing
- Active outputs are registered and change only on the clock edge at which `frame` is sampled high. They are visible the cycle after, and are stable for the whole frame.
- Write-to-visible latency: one `commit_req`, then the next `frame` edge. The minimum is 2 cycles when `frame` arrives the cycle after `commit_req`.
- `commit_pending` rises the edge after `commit_req` and falls on the committing `frame` edge.
- Reset asserted mid-frame or while ARMED clears everything asynchronously; the pending commit is lost.

## Configuration
- Macro: `SPR_AUTO_MOVE_EN`.
- **Defined:**
  - The velocity field is implemented: shadow and active `{vy[7:0], vx[7:0]}`, signed, committed together with the other fields.
  - On each `frame` that does *not* commit, every enabled sprite updates x += sign-extend(vx) and y += sign-extend(vy), wrapping at CORDW bits.
  - Disabled sprites do not move.
  - On a committing frame, the commit wins and no motion is applied that frame.
- **Undefined:** there is no velocity storage, writes to field 3 are ignored, and positions change only by commit.

## Structure
- Package `spr_pkg` holds:
  - the field codes `FLD_X`, `FLD_Y`, `FLD_CTRL`, `FLD_VEL`;
  - default `CORDW`, `NSPR`;
  - the velocity width of 8;
  - the packed struct for one sprite's attributes (x, y, en, vel).
- Sub-module `sprite_attr_entry` holds one sprite's shadow and active registers, its write decode, the commit load and the motion adder. The top instantiates NSPR entries with `generate` and owns the commit FSM and `frame_cnt`.

## Test plan
- **Reset:** after releasing `btn_rst_n`, every `spr_x`/`spr_y`/`spr_en` and `frame_cnt` is 0 and `commit_pending` = 0.
- **Write, commit, frame:** write sprite 1 x = 300, y = 215, en = 1, then pulse `commit_req`. Outputs stay 0 until `frame`, and the cycle after `frame` sprite 1 shows 300 / 215 / 1.
- **Request coincides with frame:** `commit_req` and `frame` in the same cycle leave outputs unchanged and `commit_pending` = 1. The next `frame` publishes the values.
- **Write coincides with committing frame:** shadow x = 10 is committed while x = 20 is written in the same cycle. Active = 10; after the next commit, active = 20.
- **Out-of-range index:** a write with `wr_idx` = NSPR (NSPR = 4, `IDXW` = 3) changes no output after a commit.
- **Auto-move (`SPR_AUTO_MOVE_EN`):** vx = −4, x = 2, en = 1, committed. Subsequent frames give x = −2, −6. A sprite with en = 0 stays put. `frame_cnt` advances by 1 per frame.
